// File: rtl/binarizer_pkg.sv
// Shared types and constants for the threshold binarizer slice:
// FSM state encoding, output pixel codes, pipeline latency and the
// foreground compare helper.
package binarizer_pkg;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FLUSH  = 2'd3
    } bin_state_e;

    localparam logic [7:0] PIX_FG  = 8'hFF;
    localparam logic [7:0] PIX_BG  = 8'h00;
    localparam int         BIN_LAT = 2;

    // Unsigned compare; pol=1 marks bright pixels, pol=0 marks dark ones.
    function automatic logic is_fg(input logic [7:0] gray,
                                   input logic [7:0] thr,
                                   input logic       pol);
        logic res;
        if (pol) begin
            res = (gray > thr);
        end else begin
            res = (gray <= thr);
        end
        return res;
    endfunction

endpackage

// File: rtl/thresh_capture.sv
// Frame-start edge detection and per-frame threshold register.
// The threshold only moves on a frame start seen while the FSM is idle.
// Build option THRESH_SMOOTH_EN: blend each new threshold 3:1 with the
// previous one; the first capture after reset loads the raw value.
module thresh_capture
    import binarizer_pkg::*;
#(
    parameter logic [7:0] DEFAULT_THRESH = 8'd128
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iFvalid,
    input  logic [7:0] iThresh,
    input  logic       iThreshValid,
    input  logic       iCaptureEn,
    output logic       oFrameStart,
    output logic [7:0] oThresh
);

    logic       fvalid_prev_r;
    logic [7:0] thresh_r;
    logic [7:0] thr_next_s;
    logic       capture_s;

    assign oFrameStart = iFvalid & ~fvalid_prev_r;
    assign capture_s   = iCaptureEn & oFrameStart & iThreshValid;
    assign oThresh     = thresh_r;

    // Remember last cycle's frame valid so a low-to-high step can be seen
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            fvalid_prev_r <= 1'b0;
        end else begin
            fvalid_prev_r <= iFvalid;
        end
    end

`ifdef THRESH_SMOOTH_EN
    logic captured_r;

    // (3*old + new + 2) >> 2 with a 10-bit intermediate (max 1022)
    function automatic logic [7:0] blend_thresh(input logic [7:0] old_thr,
                                                input logic [7:0] new_thr);
        logic [9:0] sum;
        sum = {2'b00, old_thr} + {1'b0, old_thr, 1'b0} + {2'b00, new_thr} + 10'd2;
        return 8'(sum >> 2);
    endfunction

    // Flag the first capture so it bypasses the blend with the default
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            captured_r <= 1'b0;
        end else if (capture_s) begin
            captured_r <= 1'b1;
        end else begin
            captured_r <= captured_r;
        end
    end

    // Next threshold: raw on first capture, blended afterwards
    always_comb begin
        thr_next_s = iThresh;
        if (captured_r) begin
            thr_next_s = blend_thresh(thresh_r, iThresh);
        end else begin
            thr_next_s = iThresh;
        end
    end
`else
    // Next threshold is the raw histogram-stage value
    always_comb begin
        thr_next_s = iThresh;
    end
`endif

    // Threshold register, loaded only at a captured frame start
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            thresh_r <= DEFAULT_THRESH;
        end else if (capture_s) begin
            thresh_r <= thr_next_s;
        end else begin
            thresh_r <= thresh_r;
        end
    end

endmodule

// File: rtl/threshold_binarizer.sv
// Binarizes the gray pixel stream against a per-frame threshold through a
// fixed two-stage pipeline and reports the foreground count at frame end.
// Optional build macro THRESH_SMOOTH_EN (threshold smoothing, in thresh_capture).
module threshold_binarizer
    import binarizer_pkg::*;
#(
    parameter int         COUNT_W        = 20,
    parameter logic [7:0] DEFAULT_THRESH = 8'd128,
    parameter bit         POLARITY       = 1'b1
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic [7:0]         iGray,
    input  logic               iGrayValid,
    input  logic               iFvalid,
    input  logic [15:0]        iX_Cont,
    input  logic [15:0]        iY_Cont,
    input  logic [7:0]         iThresh,
    input  logic               iThreshValid,
    output logic               oBin,
    output logic [7:0]         oPixel,
    output logic               oValid,
    output logic [15:0]        oX,
    output logic [15:0]        oY,
    output logic [7:0]         oThreshUsed,
    output logic [COUNT_W-1:0] oFgCount,
    output logic               oCountValid
);

    localparam logic [COUNT_W-1:0] CNT_MAX    = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_ONE    = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]         FLUSH_LAST = 2'(BIN_LAT - 1);

    bin_state_e         state_r;
    logic [1:0]         flush_cnt_r;
    logic [COUNT_W-1:0] fg_cnt_r;

    logic               s1_valid_r;
    logic [7:0]         s1_gray_r;
    logic [15:0]        s1_x_r;
    logic [15:0]        s1_y_r;

    logic               frame_start_s;
    logic               capture_en_s;
    logic [7:0]         thresh_s;
    logic               fg_s;

    assign capture_en_s = (state_r == ST_IDLE);
    assign oThreshUsed  = thresh_s;

    thresh_capture #(
        .DEFAULT_THRESH (DEFAULT_THRESH)
    ) u_thresh_capture (
        .iClk         (iClk),
        .iRst_n       (iRst_n),
        .iFvalid      (iFvalid),
        .iThresh      (iThresh),
        .iThreshValid (iThreshValid),
        .iCaptureEn   (capture_en_s),
        .oFrameStart  (frame_start_s),
        .oThresh      (thresh_s)
    );

    // Stage-2 foreground decision for the pixel held in stage 1
    always_comb begin
        fg_s = 1'b0;
        if (s1_valid_r) begin
            fg_s = is_fg(s1_gray_r, thresh_s, POLARITY);
        end else begin
            fg_s = 1'b0;
        end
    end

    // Two-stage pixel pipeline; pixels outside ACTIVE are dropped at stage 1
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            s1_valid_r <= 1'b0;
            s1_gray_r  <= 8'd0;
            s1_x_r     <= 16'd0;
            s1_y_r     <= 16'd0;
            oValid     <= 1'b0;
            oBin       <= 1'b0;
            oPixel     <= PIX_BG;
            oX         <= 16'd0;
            oY         <= 16'd0;
        end else begin
            s1_valid_r <= iGrayValid & (state_r == ST_ACTIVE);
            s1_gray_r  <= iGray;
            s1_x_r     <= iX_Cont;
            s1_y_r     <= iY_Cont;
            oValid     <= s1_valid_r;
            oBin       <= fg_s;
            oPixel     <= fg_s ? PIX_FG : PIX_BG;
            if (s1_valid_r) begin
                oX <= s1_x_r;
                oY <= s1_y_r;
            end else begin
                oX <= oX;
                oY <= oY;
            end
        end
    end

    // Frame FSM with saturating foreground counter and end-of-frame report
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_r     <= ST_SYNC;
            flush_cnt_r <= 2'd0;
            fg_cnt_r    <= {COUNT_W{1'b0}};
            oFgCount    <= {COUNT_W{1'b0}};
            oCountValid <= 1'b0;
        end else begin
            oCountValid <= 1'b0;
            if (fg_s && (fg_cnt_r != CNT_MAX)) begin
                fg_cnt_r <= fg_cnt_r + CNT_ONE;
            end else begin
                fg_cnt_r <= fg_cnt_r;
            end
            case (state_r)
                ST_SYNC: begin
                    if (!iFvalid) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_SYNC;
                    end
                end
                ST_IDLE: begin
                    if (frame_start_s) begin
                        fg_cnt_r <= {COUNT_W{1'b0}};
                        state_r  <= ST_ACTIVE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (!iFvalid) begin
                        flush_cnt_r <= 2'd0;
                        state_r     <= ST_FLUSH;
                    end else begin
                        state_r <= ST_ACTIVE;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_r == FLUSH_LAST) begin
                        oFgCount    <= fg_cnt_r;
                        oCountValid <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        flush_cnt_r <= flush_cnt_r + 2'd1;
                        state_r     <= ST_FLUSH;
                    end
                end
                default: begin
                    state_r <= ST_SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_threshold_binarizer.sv
// Scoreboard bench: three binarizer instances share one stimulus stream
// (default, COUNT_W=4, POLARITY=0). Stimulus pushes hand-computed expected
// pixels and counts; a negedge monitor pops and compares on oValid/oCountValid.
module tb_threshold_binarizer;

    typedef struct packed {
        logic        bin;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  thr;
    } exp_t;

`ifdef THRESH_SMOOTH_EN
    localparam logic [7:0] S2_THR = 8'd125;
    localparam logic       S2_B1  = 1'b1;
`else
    localparam logic [7:0] S2_THR = 8'd200;
    localparam logic       S2_B1  = 1'b0;
`endif

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic [7:0]  iGray;
    logic        iGrayValid;
    logic        iFvalid;
    logic [15:0] iX_Cont;
    logic [15:0] iY_Cont;
    logic [7:0]  iThresh;
    logic        iThreshValid;

    logic        m_bin[3];
    logic        m_valid[3];
    logic        m_cv[3];
    logic [7:0]  m_pix[3];
    logic [7:0]  m_thr[3];
    logic [15:0] m_x[3];
    logic [15:0] m_y[3];
    logic [19:0] cnt_main;
    logic [3:0]  cnt_sat;
    logic [19:0] cnt_pol;
    logic [19:0] m_cnt[3];

    exp_t        pq[3][$];
    logic [19:0] cq[3][$];
    logic [7:0]  exp_thr;
    int          checks = 0;
    int          errors = 0;

    assign m_cnt[0] = cnt_main;
    assign m_cnt[1] = {16'd0, cnt_sat};
    assign m_cnt[2] = cnt_pol;

    always #5 iClk = ~iClk;

    threshold_binarizer u_main (
        .iClk(iClk), .iRst_n(iRst_n), .iGray(iGray), .iGrayValid(iGrayValid),
        .iFvalid(iFvalid), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
        .iThresh(iThresh), .iThreshValid(iThreshValid),
        .oBin(m_bin[0]), .oPixel(m_pix[0]), .oValid(m_valid[0]),
        .oX(m_x[0]), .oY(m_y[0]), .oThreshUsed(m_thr[0]),
        .oFgCount(cnt_main), .oCountValid(m_cv[0])
    );

    threshold_binarizer #(.COUNT_W(4)) u_sat (
        .iClk(iClk), .iRst_n(iRst_n), .iGray(iGray), .iGrayValid(iGrayValid),
        .iFvalid(iFvalid), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
        .iThresh(iThresh), .iThreshValid(iThreshValid),
        .oBin(m_bin[1]), .oPixel(m_pix[1]), .oValid(m_valid[1]),
        .oX(m_x[1]), .oY(m_y[1]), .oThreshUsed(m_thr[1]),
        .oFgCount(cnt_sat), .oCountValid(m_cv[1])
    );

    threshold_binarizer #(.POLARITY(1'b0)) u_pol (
        .iClk(iClk), .iRst_n(iRst_n), .iGray(iGray), .iGrayValid(iGrayValid),
        .iFvalid(iFvalid), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
        .iThresh(iThresh), .iThreshValid(iThreshValid),
        .oBin(m_bin[2]), .oPixel(m_pix[2]), .oValid(m_valid[2]),
        .oX(m_x[2]), .oY(m_y[2]), .oThreshUsed(m_thr[2]),
        .oFgCount(cnt_pol), .oCountValid(m_cv[2])
    );

    // Monitor: compare every presented pixel and count against the scoreboard
    always @(negedge iClk) begin
        exp_t        e;
        logic [19:0] ec;
        logic [7:0]  epix;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (m_valid[d]) begin
                if (pq[d].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid dut=%0d got x=%0d y=%0d bin=%0d, want no output",
                             d, m_x[d], m_y[d], m_bin[d]);
                end else begin
                    e = pq[d].pop_front();
                    epix = e.bin ? 8'hFF : 8'h00;
                    if (m_bin[d] !== e.bin || m_pix[d] !== epix || m_x[d] !== e.x ||
                        m_y[d] !== e.y || m_thr[d] !== e.thr) begin
                        errors++;
                        $display("FAIL pixel dut=%0d got bin=%0d pix=%h x=%0d y=%0d thr=%0d want bin=%0d pix=%h x=%0d y=%0d thr=%0d",
                                 d, m_bin[d], m_pix[d], m_x[d], m_y[d], m_thr[d],
                                 e.bin, epix, e.x, e.y, e.thr);
                    end
                end
            end else if (m_bin[d] !== 1'b0 || m_pix[d] !== 8'h00) begin
                errors++;
                $display("FAIL idle_zero dut=%0d got bin=%0d pix=%h want 0/00", d, m_bin[d], m_pix[d]);
            end
            if (m_cv[d]) begin
                checks++;
                if (cq[d].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_count dut=%0d got count=%0d, want no pulse", d, m_cnt[d]);
                end else begin
                    ec = cq[d].pop_front();
                    if (m_cnt[d] !== ec) begin
                        errors++;
                        $display("FAIL fg_count dut=%0d got=%0d want=%0d", d, m_cnt[d], ec);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        iRst_n = 1'b0;
        tick(2);
        iRst_n = 1'b1;
        tick(2);
    endtask

    task automatic frame_start(input logic tv, input logic [7:0] th);
        iThreshValid = tv;
        iThresh      = th;
        iFvalid      = 1'b1;
        tick(2);
    endtask

    // One pixel with its expected result for POLARITY=1 (b1) and POLARITY=0 (b0)
    task automatic pix(input logic [7:0] g, input logic b1, input logic b0,
                       input logic [15:0] x, input logic [15:0] y);
        iGray      = g;
        iGrayValid = 1'b1;
        iX_Cont    = x;
        iY_Cont    = y;
        pq[0].push_back('{bin: b1, x: x, y: y, thr: exp_thr});
        pq[1].push_back('{bin: b1, x: x, y: y, thr: exp_thr});
        pq[2].push_back('{bin: b0, x: x, y: y, thr: exp_thr});
        tick(1);
        iGrayValid = 1'b0;
    endtask

    task automatic frame_end(input logic [19:0] c_main, input logic [19:0] c_sat,
                             input logic [19:0] c_pol);
        iFvalid = 1'b0;
        cq[0].push_back(c_main);
        cq[1].push_back(c_sat);
        cq[2].push_back(c_pol);
        tick(6);
    endtask

    // Directed stimulus
    initial begin
        iRst_n = 1'b0; iGray = 8'd0; iGrayValid = 1'b0; iFvalid = 1'b0;
        iX_Cont = 16'd0; iY_Cont = 16'd0; iThresh = 8'd0; iThreshValid = 1'b0;
        exp_thr = 8'd128;

        // Reset state
        do_reset();
        chk("rst_valid", {31'd0, m_valid[0]}, 32'd0);
        chk("rst_bin", {31'd0, m_bin[0]}, 32'd0);
        chk("rst_pixel", {24'd0, m_pix[0]}, 32'd0);
        chk("rst_x", {16'd0, m_x[0]}, 32'd0);
        chk("rst_y", {16'd0, m_y[0]}, 32'd0);
        chk("rst_thresh", {24'd0, m_thr[0]}, 32'd128);
        chk("rst_count", {12'd0, cnt_main}, 32'd0);
        chk("rst_count_valid", {31'd0, m_cv[0]}, 32'd0);

        // Default threshold 128, no valid threshold yet
        exp_thr = 8'd128;
        frame_start(1'b0, 8'd0);
        pix(8'd0,   1'b0, 1'b1, 16'd1, 16'd1);
        pix(8'd128, 1'b0, 1'b1, 16'd2, 16'd1);
        pix(8'd129, 1'b1, 1'b0, 16'd3, 16'd1);
        pix(8'd255, 1'b1, 1'b0, 16'd4, 16'd1);
        frame_end(20'd2, 20'd2, 20'd2);

        // Captured 200; mid-frame change to 10 must be ignored
        do_reset();
        exp_thr = 8'd200;
        frame_start(1'b1, 8'd200);
        pix(8'd200, 1'b0, 1'b1, 16'd10, 16'd2);
        iThresh = 8'd10;
        pix(8'd201, 1'b1, 1'b0, 16'd11, 16'd2);
        tick(2);
        chk("thresh_midframe", {24'd0, m_thr[0]}, 32'd200);
        frame_end(20'd1, 20'd1, 20'd1);
        chk("thresh_after_frame", {24'd0, m_thr[0]}, 32'd200);

        // Threshold 50 boundary in both polarities
        do_reset();
        exp_thr = 8'd50;
        frame_start(1'b1, 8'd50);
        pix(8'd50, 1'b0, 1'b1, 16'd20, 16'd3);
        pix(8'd51, 1'b1, 1'b0, 16'd21, 16'd3);
        frame_end(20'd1, 20'd1, 20'd1);

        // Two captures: 100 then 200 (blended to 125 when smoothing is built in)
        do_reset();
        exp_thr = 8'd100;
        frame_start(1'b1, 8'd100);
        pix(8'd150, 1'b1, 1'b0, 16'd30, 16'd4);
        frame_end(20'd1, 20'd1, 20'd0);
        exp_thr = S2_THR;
        frame_start(1'b1, 8'd200);
        pix(8'd150, S2_B1, ~S2_B1, 16'd31, 16'd4);
        frame_end({19'd0, S2_B1}, {19'd0, S2_B1}, {19'd0, ~S2_B1});
        chk("thresh_second_capture", {24'd0, m_thr[0]}, {24'd0, S2_THR});

        // Reset in the middle of a frame
        do_reset();
        exp_thr = 8'd77;
        frame_start(1'b1, 8'd77);
        pix(8'd100, 1'b1, 1'b0, 16'd40, 16'd5);
        frame_end(20'd1, 20'd1, 20'd0);
        frame_start(1'b0, 8'd0);
        pix(8'd100, 1'b1, 1'b0, 16'd41, 16'd5);
        tick(4);
        chk("count_before_midreset", {12'd0, cnt_main}, 32'd1);
        iRst_n = 1'b0;
        tick(1);
        chk("midreset_count", {12'd0, cnt_main}, 32'd0);
        chk("midreset_thresh", {24'd0, m_thr[0]}, 32'd128);
        chk("midreset_x", {16'd0, m_x[0]}, 32'd0);
        tick(1);
        iRst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            iGray = 8'd200; iGrayValid = 1'b1; iX_Cont = 16'(100 + i); iY_Cont = 16'd6;
            tick(1);
        end
        iGrayValid = 1'b0;
        iFvalid    = 1'b0;
        tick(3);

        // Next frame counts normally; 20 foreground pixels saturate the 4-bit counter
        exp_thr = 8'd0;
        frame_start(1'b1, 8'd0);
        for (int i = 0; i < 20; i++) begin
            pix(8'd200, 1'b1, 1'b0, 16'(50 + i), 16'd7);
        end
        frame_end(20'd20, 20'd15, 20'd0);

        // Zero-length frame
        iThreshValid = 1'b0;
        iFvalid      = 1'b1;
        tick(1);
        frame_end(20'd0, 20'd0, 20'd0);
        chk("zero_frame_thresh", {24'd0, m_thr[0]}, 32'd0);

        tick(4);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("pixels_left_dut%0d", d), pq[d].size(), 32'd0);
            chk($sformatf("counts_left_dut%0d", d), cq[d].size(), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/threshold_binarizer.md
Name: threshold_binarizer

Overview:
- Downstream consumer of the histogram/threshold stage.
- Latches the per-frame threshold at each frame start and binarizes the live gray pixel stream against it through a fixed 2-cycle pipeline.
- Counts foreground pixels per frame and reports the count at frame end.
- Output feeds the display/mask path and the frame statistics logic.

Parameters:
- COUNT_W, 20, width of the foreground pixel counter (fits 640x480).
- DEFAULT_THRESH, 128, threshold applied until the first valid threshold is captured.
- POLARITY, 1: foreground when gray > thresh if 1; foreground when gray <= thresh if 0.

Ports:
- iClk  in  1  clock.
- iRst_n  in  1  synchronous active-low reset.
- iGray  in  8  gray pixel.
- iGrayValid  in  1  pixel qualifier.
- iFvalid  in  1  frame valid, high for the whole active frame.
- iX_Cont  in  16  pixel column.
- iY_Cont  in  16  pixel row.
- iThresh  in  8  threshold from the histogram stage.
- iThreshValid  in  1  high once iThresh holds a computed value; level, may stay high.
- oBin  out  1  binary pixel, 1 = foreground.
- oPixel  out  8  8'hFF if oBin else 8'h00.
- oValid  out  1  qualifier for oBin/oPixel/oX/oY.
- oX  out  16  column aligned with oBin.
- oY  out  16  row aligned with oBin.
- oThreshUsed  out  8  threshold applied to the current/last frame.
- oFgCount  out  COUNT_W  foreground count of the last completed frame.
- oCountValid  out  1  one-cycle pulse when oFgCount updates.

Behaviour:
- Reset: iRst_n, synchronous, active-low; clock iClk. All outputs 0 except oThreshUsed = DEFAULT_THRESH. Internal counter 0, capture flag cleared, state SYNC.
- States:
  - SYNC: wait for iFvalid low, then go to IDLE. Ensures a frame in progress at reset is ignored entirely.
  - IDLE: on the rising edge of iFvalid (registered prev low, current high):
    - If iThreshValid, capture iThresh (smoothing per optional feature) into the threshold register; otherwise keep the current register.
    - Clear the counter; go to ACTIVE.
  - ACTIVE: process pixels. When iFvalid goes low, go to FLUSH.
  - FLUSH: wait 2 cycles to drain the pipeline, then:
    - Load oFgCount from the counter.
    - Pulse oCountValid for 1 cycle.
    - Go to IDLE.
- Threshold register changes only at a frame start. Changes to iThresh mid-frame are ignored.
- Pipeline, fixed latency 2:
  - Stage 1 registers iGray, iGrayValid, iX_Cont, iY_Cont (valid forced 0 outside ACTIVE).
  - Stage 2 compares against the threshold register and drives oBin/oPixel/oValid/oX/oY.
  - When oValid is 0, oBin = 0 and oPixel = 0; oX/oY hold their last values.
- Compare: unsigned 8-bit. POLARITY=1 gives fg = gray > thresh, so thresh 255 yields no foreground. POLARITY=0 gives fg = gray <= thresh.
- Counter:
  - Increments when stage 2 valid and fg.
  - Saturates at all-ones; no wrap.
- Simultaneous events:
  - iFvalid rising in the same cycle FLUSH completes: count reported, rising edge missed, next frame skipped (one-frame drop is acceptable and documented).
  - FLUSH pixels in flight still count.
- Reset mid-frame: outputs cleared next cycle, return to SYNC, remainder of the frame produces no oValid.
- Zero-length frame (iFvalid high for 1 cycle, no valid pixels): oCountValid pulses with oFgCount = 0.

Optional Feature:
- Macro THRESH_SMOOTH_EN.
- Defined: at capture, thr_new = (3*thr_old + iThresh + 2) >> 2, computed with 10-bit intermediate. The first capture after reset loads iThresh directly (no blend with DEFAULT_THRESH).
- Undefined: thr_new = iThresh.

Decomposition:
- Shared package (binarizer_pkg):
  - State enum encoding: SYNC, IDLE, ACTIVE, FLUSH.
  - PIX_FG = 8'hFF, PIX_BG = 8'h00.
  - Pipeline latency constant BIN_LAT = 2.
- One natural sub-module, thresh_capture: frame-start edge detect, capture flag, optional smoothing, threshold register. The top holds the FSM, pipeline and counter.

Test Plan:
- Reset, iThreshValid=0, 4-pixel frame with grays 0,128,129,255 -> oBin 0,0,1,1 two cycles after each input; oFgCount=2, oCountValid pulses once after iFvalid falls.
- iThreshValid=1, iThresh=200 at frame start, iThresh changed to 10 mid-frame -> oThreshUsed=200 for the whole frame; grays 200 and 201 give oBin 0 and 1.
- THRESH_SMOOTH_EN defined: frames with iThresh 100, then 200 -> oThreshUsed 100, then 125.
- Reset asserted mid-frame with iFvalid high -> no oValid until iFvalid falls and rises again; the next frame counts normally.
- COUNT_W=4, 20 foreground pixels -> oFgCount=15 (saturated).
- POLARITY=0, thresh 50, grays 50 and 51 -> oBin 1 and 0; oPixel FF and 00.
